// File: rtl/sid.sv
// Shared SID core types.
// Sub-cycle counter used to time-multiplex the voice slots.
package sid;

    typedef logic [4:0] cycle_t;

endpackage

// File: rtl/sid_dca.sv
// Voice amplifier: waveform x envelope per slot, summed per chip.
// Three-stage pipeline over six time-multiplexed voice slots.
module sid_dca
    import sid::*;
#(
    parameter int WAV_BITS = 12,
    parameter int ENV_BITS = 8,
    parameter int MIX_BITS = 22
) (
    input  logic                               clk,
    input  logic                               res_n,
    input  cycle_t                             cycle,
    input  logic        [WAV_BITS-1:0]         wav,
    input  logic        [ENV_BITS-1:0]         env,
    input  logic                               mute,
    output logic signed [WAV_BITS+ENV_BITS-1:0] voice_out,
    output logic signed [MIX_BITS-1:0]         mix0,
    output logic signed [MIX_BITS-1:0]         mix1,
    output logic        [1:0]                  mix_stb
);

    localparam int PROD_BITS = WAV_BITS + ENV_BITS;

    logic                        in_win;
    logic                        s1_vld;
    logic [2:0]                  s1_slot;
    logic signed [WAV_BITS-1:0]  s1_s;
    logic [ENV_BITS-1:0]         s1_env;
    logic                        s1_mute;

    logic                        s2_vld;
    logic [2:0]                  s2_slot;
    logic signed [PROD_BITS-1:0] s2_prod;

    logic signed [PROD_BITS-1:0] op_a;
    logic signed [PROD_BITS-1:0] op_b;
    logic signed [PROD_BITS-1:0] prod;

    logic signed [MIX_BITS-1:0]  acc [2];
    logic                        arm [2];
    logic signed [MIX_BITS-1:0]  ext;
    logic signed [MIX_BITS-1:0]  sum;
    logic                        chip;
    logic [1:0]                  pos;

    assign in_win = (cycle >= cycle_t'(6)) && (cycle <= cycle_t'(11));

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            s1_vld  <= 1'b0;
            s1_slot <= '0;
            s1_s    <= '0;
            s1_env  <= '0;
            s1_mute <= 1'b0;
        end else begin
            s1_vld <= in_win;
            if (in_win) begin
                s1_slot <= 3'(cycle - cycle_t'(6));
                s1_s    <= {~wav[WAV_BITS-1], wav[WAV_BITS-2:0]};
                s1_env  <= env;
                s1_mute <= mute;
            end
        end
    end

    // Envelope is unsigned: zero-extend it before the signed multiply.
    assign op_a = {{ENV_BITS{s1_s[WAV_BITS-1]}}, s1_s};
    assign op_b = {{WAV_BITS{1'b0}}, s1_env};
    assign prod = op_a * op_b;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            s2_vld  <= 1'b0;
            s2_slot <= '0;
            s2_prod <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_slot <= s1_slot;
                s2_prod <= s1_mute ? '0 : prod;
            end
        end
    end

    always_comb begin
        chip = 1'b0;
        pos  = 2'd3;
        unique case (s2_slot)
            3'd0: begin chip = 1'b0; pos = 2'd0; end
            3'd1: begin chip = 1'b0; pos = 2'd1; end
            3'd2: begin chip = 1'b0; pos = 2'd2; end
            3'd3: begin chip = 1'b1; pos = 2'd0; end
            3'd4: begin chip = 1'b1; pos = 2'd1; end
            3'd5: begin chip = 1'b1; pos = 2'd2; end
            default: ;
        endcase
    end

    assign ext = {{(MIX_BITS-PROD_BITS){s2_prod[PROD_BITS-1]}}, s2_prod};
    assign sum = acc[chip] + ext;

    // A chip only publishes after seeing its first voice since reset.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            voice_out <= '0;
            mix0      <= '0;
            mix1      <= '0;
            mix_stb   <= '0;
            acc[0]    <= '0;
            acc[1]    <= '0;
            arm[0]    <= 1'b0;
            arm[1]    <= 1'b0;
        end else begin
            mix_stb <= '0;
            if (s2_vld) begin
                voice_out <= s2_prod;
                unique case (pos)
                    2'd0: begin
                        acc[chip] <= ext;
                        arm[chip] <= 1'b1;
                    end
                    2'd1: acc[chip] <= sum;
                    2'd2: begin
                        if (arm[chip]) begin
                            if (chip) mix1 <= sum;
                            else      mix0 <= sum;
                            mix_stb[chip] <= 1'b1;
                            arm[chip]     <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sid_dca.sv
// Self-checking bench for sid_dca.
// Frame-level voice model plus literal expectations.
module tb_sid_dca;
    import sid::*;

    typedef logic [11:0] wv_t [6];
    typedef logic [7:0]  ev_t [6];
    typedef bit          mv_t [6];

    logic                clk = 1'b0;
    logic                res_n = 1'b0;
    cycle_t              cycle = '0;
    logic [11:0]         wav = '0;
    logic [7:0]          env = '0;
    logic                mute = 1'b0;
    logic signed [19:0]  voice_out;
    logic signed [21:0]  mix0;
    logic signed [21:0]  mix1;
    logic [1:0]          mix_stb;

    int errors = 0;
    int checks = 0;

    sid_dca dut (
        .clk       (clk),
        .res_n     (res_n),
        .cycle     (cycle),
        .wav       (wav),
        .env       (env),
        .mute      (mute),
        .voice_out (voice_out),
        .mix0      (mix0),
        .mix1      (mix1),
        .mix_stb   (mix_stb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each captured slot takes effect two edges later.
    int     m_vo;
    int     m_mix [2];
    int     m_sum [2];
    bit     m_arm [2];
    bit [1:0] m_stb;
    bit     h_v [2];
    int     h_slot [2];
    int     h_p [2];
    logic   r_s;
    int     c_s;
    int     w_s;
    int     e_s;
    logic   mu_s;

    function automatic void apply(input int slot, input int p);
        int ch;
        int ps;
        ch = slot / 3;
        ps = slot % 3;
        m_vo = p;
        if (ps == 0) begin
            m_sum[ch] = p;
            m_arm[ch] = 1'b1;
        end else if (ps == 1) begin
            m_sum[ch] += p;
        end else if (m_arm[ch]) begin
            m_mix[ch] = m_sum[ch] + p;
            m_stb[ch] = 1'b1;
            m_arm[ch] = 1'b0;
        end
    endfunction

    initial begin
        m_vo = 0;
        m_stb = '0;
        for (int i = 0; i < 2; i++) begin
            m_mix[i] = 0; m_sum[i] = 0; m_arm[i] = 0;
            h_v[i] = 0; h_slot[i] = 0; h_p[i] = 0;
        end
    end

    always begin
        @(posedge clk);
        r_s  = res_n;
        c_s  = int'(cycle);
        w_s  = int'(wav);
        e_s  = int'(env);
        mu_s = mute;
        #1;
        if (!r_s) begin
            m_vo = 0;
            m_stb = '0;
            for (int i = 0; i < 2; i++) begin
                m_mix[i] = 0; m_sum[i] = 0; m_arm[i] = 0;
                h_v[i] = 0;
            end
        end else begin
            m_stb = '0;
            if (h_v[1]) apply(h_slot[1], h_p[1]);
            h_v[1]    = h_v[0];
            h_slot[1] = h_slot[0];
            h_p[1]    = h_p[0];
            h_v[0]    = (c_s >= 6 && c_s <= 11);
            h_slot[0] = c_s - 6;
            h_p[0]    = mu_s ? 0 : (w_s - 2048) * e_s;
        end
        chk("mdl_stb", mix_stb, m_stb);
        chk("mdl_mix0", mix0, m_mix[0]);
        chk("mdl_mix1", mix1, m_mix[1]);
        chk("mdl_voice", voice_out, m_vo);
    end

    // One SID cycle of 20 sub-cycles; junk is driven outside the slot window.
    task automatic frame(input wv_t w, input ev_t e, input mv_t m,
                         input int rlo, input int rhi,
                         input logic [1:0] s11, input logic [1:0] s14);
        logic [1:0] es;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == rlo) res_n = 1'b0;
            if (c == rhi) res_n = 1'b1;
            cycle = cycle_t'(c);
            if (c >= 6 && c <= 11) begin
                wav  = w[c-6];
                env  = e[c-6];
                mute = m[c-6];
            end else begin
                wav  = 12'($urandom);
                env  = 8'($urandom);
                mute = 1'($urandom);
            end
            es = (c == 11) ? s11 : (c == 14) ? s14 : 2'b00;
            chk("stb_timing", mix_stb, es);
        end
    endtask

    wv_t w_ff, w_00, w_80, w_d, w_f;
    ev_t e_ff, e_mx, e_d;
    mv_t m_no, m_2;

    initial begin
        w_ff = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        w_00 = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
        w_80 = '{12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800};
        w_d  = '{12'hFFF, 12'h000, 12'h123, 12'h900, 12'h900, 12'h900};
        w_f  = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000};
        e_ff = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        e_mx = '{8'h37, 8'hFF, 8'h01, 8'h80, 8'hC3, 8'h5A};
        e_d  = '{8'h80, 8'h40, 8'h00, 8'h10, 8'h10, 8'h10};
        m_no = '{0, 0, 0, 0, 0, 0};
        m_2  = '{0, 0, 1, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_mix0", mix0, 0);
        chk("rst_mix1", mix1, 0);
        chk("rst_voice", voice_out, 0);
        chk("rst_stb", mix_stb, 0);
        res_n = 1'b1;

        frame(w_ff, e_ff, m_no, -1, -1, 2'b01, 2'b10);
        chk("max_mix0", mix0, 1565955);
        chk("max_mix1", mix1, 1565955);
        chk("max_voice", voice_out, 521985);
        frame(w_ff, e_ff, m_no, -1, -1, 2'b01, 2'b10);
        chk("max2_mix0", mix0, 1565955);

        frame(w_00, e_ff, m_no, -1, -1, 2'b01, 2'b10);
        chk("min_mix0", mix0, -1566720);
        chk("min_mix1", mix1, -1566720);
        chk("min_voice", voice_out, -522240);

        frame(w_80, e_mx, m_no, -1, -1, 2'b01, 2'b10);
        chk("mid_mix0", mix0, 0);
        chk("mid_mix1", mix1, 0);

        frame(w_d, e_d, m_no, -1, -1, 2'b01, 2'b10);
        chk("mixed_mix0", mix0, 130944);
        chk("mixed_mix1", mix1, 12288);

        frame(w_ff, e_ff, m_2, -1, -1, 2'b01, 2'b10);
        chk("mute_mix0", mix0, 1043970);
        chk("mute_mix1", mix1, 1565955);

        frame(w_f, e_ff, m_no, 7, 9, 2'b00, 2'b10);
        chk("rstmid_mix0", mix0, 0);
        chk("rstmid_mix1", mix1, -1566720);

        frame(w_d, e_d, m_no, -1, -1, 2'b01, 2'b10);
        chk("after_mix0", mix0, 130944);
        chk("after_mix1", mix1, 12288);

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cycle = (i % 2 == 0) ? cycle_t'($urandom_range(5, 0))
                                 : cycle_t'($urandom_range(31, 12));
            wav  = 12'($urandom);
            env  = 8'($urandom);
            mute = 1'($urandom);
            chk("idle_stb", mix_stb, 0);
        end
        chk("idle_mix0", mix0, 130944);
        chk("idle_mix1", mix1, 12288);
        chk("idle_voice", voice_out, 4096);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sid_dca.md
Name: sid_dca

Overview:
- Digitally controlled amplifier stage directly downstream of sid_envelope, time-multiplexed over the 6 voice slots (2 SID chips × 3 voices).
- In each slot it captures the voice waveform output and the envelope output `env`, forms the signed product, and sums the three voices of each chip.
- Presents one registered 22-bit signed mix per chip, with a one-clock strobe, to the filter/mixer path.

Parameters:
- WAV_BITS, 12, waveform sample width (unsigned, midpoint 2^(WAV_BITS-1)).
- ENV_BITS, 8, envelope width (unsigned).
- MIX_BITS, 22, per-chip mix width (signed); must be ≥ WAV_BITS+ENV_BITS+2.

Ports:
- clk  in  1  system clock.
- res_n  in  1  asynchronous, active-low reset.
- cycle  in  sid::cycle_t  FPGA sub-cycle counter; voice slot k is valid at cycle == 6+k, for k = 0..5.
- wav  in  WAV_BITS  waveform sample of the current slot, valid at cycles 6..11.
- env  in  ENV_BITS  envelope value of the current slot (sid_envelope output), valid at cycles 6..11.
- mute  in  1  per-slot voice mute (e.g. voice 3 off), valid at cycles 6..11.
- voice_out  out  WAV_BITS+ENV_BITS  signed product of the most recent slot (debug/osc3 tap).
- mix0  out  MIX_BITS  signed sum of slots 0..2 (chip 0).
- mix1  out  MIX_BITS  signed sum of slots 3..5 (chip 1).
- mix_stb  out  2  one-clock strobes: bit 0 when mix0 updates, bit 1 when mix1 updates.

Behaviour:
- Reset (res_n low, asynchronous): all pipeline registers, accumulators, voice_out, mix0, mix1, mix_stb, arm0 and arm1 are 0. Takes effect immediately, including mid-frame.
- Stage 1 (every clk):
  - s1_vld <= (cycle >= 6 && cycle <= 11); s1_slot <= cycle-6.
  - s1_s <= {~wav[MSB], wav[MSB-1:0]} as signed, i.e. wav - 2048 (range -2048..2047).
  - s1_env <= env; s1_mute <= mute.
  - When s1_vld is 0, the data registers hold their previous values.
- Stage 2 (every clk):
  - s2_vld <= s1_vld; s2_slot <= s1_slot.
  - s2_prod <= s1_mute ? 0 : s1_s × {1'b0, s1_env}, computed signed, WAV_BITS+ENV_BITS = 20 bits.
  - Range -522240..521985; no saturation is required.
  - voice_out <= s2_prod when s2_vld.
- Stage 3 (only when s2_vld; chip c = s2_slot/3, position p = s2_slot%3):
  - p == 0: acc_c <= sign-extended s2_prod; arm_c <= 1.
  - p == 1: acc_c <= acc_c + s2_prod.
  - p == 2 and arm_c: mix_c <= acc_c + s2_prod; mix_stb[c] pulses for 1 clk; arm_c <= 0.
  - p == 2 and !arm_c: no update, no strobe.
- Latency: slot k captured at the clk edge ending cycle 6+k; its product is registered at the next edge. mix0 and mix_stb[0] are visible in the cycle after the edge ending cycle 10; mix1 and mix_stb[1] in the cycle after the edge ending cycle 13.
- mix_stb is 0 in every other clock.
- The sum of three voices is bounded at ±1566720, which fits 22-bit signed; no overflow handling is needed.
- mix0 and mix1 hold their value between strobes.
- If cycle skips or repeats a slot, the stage-3 rules are applied literally. Only a p == 0 slot arms a chip.
- Reset released mid-frame: no strobe occurs until a full 0..2 (or 3..5) sequence has been accumulated.
- Cycles outside 6..11 produce no accumulator change.

Test Plan:
- All slots wav=0xFFF, env=0xFF, mute=0 -> voice_out=521985 per slot; mix0 = mix1 = 1565955; mix_stb[0] and mix_stb[1] each pulse once per SID cycle at the specified clocks.
- All slots wav=0x000, env=0xFF -> mix0 = mix1 = -1566720; wav=0x800, any env -> mix0 = mix1 = 0.
- Slot 0 wav=0xFFF, env=0x80; slot 1 wav=0x000, env=0x40; slot 2 env=0x00 -> mix0 = 2047×128 - 2048×64 = 130944.
- mute=1 on slot 2 only, all others wav=0xFFF, env=0xFF -> mix0 = 1043970; mix1 = 1565955.
- Assert res_n low during cycle 7, release at cycle 9 -> no mix_stb[0] in that SID cycle; mix_stb[1] fires with the slots 3..5 sum; the next SID cycle gives a normal mix0.
- Hold cycle outside 6..11 for 100 clks -> mix0, mix1 and voice_out stable; mix_stb stays 0.
